hi_read_rx_xcorr_mc: RTL
========================

# hi_read_rx_xcorr_mc

Parametrised HF reader-mode subcarrier correlator. It takes 13.56 MS/s ADC samples and correlates them against in-phase and quadrature square-wave references. Four subcarrier rates are selectable at run time, as are gain shift and tag-detect threshold. Saturated I/Q results stream to the ARM over SSP, with the reader-side AM hysteresis bit embedded in snoop mode.

## Interface
Parameters:
- ADC_W, 8, ADC sample width (unsigned).
- WIN_LOG2, 7, log2 of correlation window in samples; legal 6..10.
- OUT_W, 8, signed output word width per channel; 8*OUT_W <= 2^WIN_LOG2 required.
- HYST_W, 12, width of the hysteresis low-timeout counter.

Ports:
- adc_clk  in  1  sample clock; all registers update on falling edge.
- reset  in  1  asynchronous, active-high; clears all state.
- adc_d  in  ADC_W  ADC sample, valid at falling edge.
- sc_mode  in  2  subcarrier: 00 848 kHz, 01 424 kHz, 10 212 kHz, 11 106 kHz.
- gain_shift  in  4  arithmetic right shift applied before saturation.
- thresh  in  OUT_W  tag-detect threshold (unsigned).
- snoop  in  1  embed reader AM bit in output LSBs.
- ssp_clk  out  1  serial clock, adc_clk/4.
- ssp_frame  out  1  high for first 4 samples of each window.
- ssp_din  out  1  serial data, MSB first, I word then Q word.
- corr_valid  out  1  one-cycle pulse when new I/Q pair loaded.
- tag_detect  out  1  |I|+|Q| >= thresh, updated per window.
- dbg  out  1  cnt[3].

## Operation
- Sample counter cnt, WIN_LOG2 bits, free-running, wraps 2^WIN_LOG2-1 -> 0.
- sc_mode, gain_shift, thresh, snoop captured into shadow registers at cnt==0 only; mid-window changes take effect next window.
- Reference bit b = 3 + sc_mode_q, clamped to WIN_LOG2-1. refI = ~cnt[b]; refQ = ~(cnt[b] ^ cnt[b-1]).
- Accumulators acc_i/acc_q: signed, ADC_W+WIN_LOG2+1 bits. At cnt==0 both load +adc_d (both refs high). Otherwise each adds adc_d if its ref is 1, subtracts if 0. No overflow is possible.
- Output at cnt==0, from the finished window: s = acc >>> gain_shift_q (arithmetic).
  - Normal mode: out = s saturated to OUT_W signed, [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Snoop mode: out = {sat_{OUT_W-1}(s >>> 1), hbit}. hbit for I is the hysteresis bit captured at the previous window start. hbit for Q is the one captured at cnt==2^(WIN_LOG2-1).
- tag_detect <= (|out_i| + |out_q|) >= thresh_q. Computed from the normal-mode value, OUT_W+1-bit unsigned compare.
- Hysteresis:
  - after_hyst <= 1 when adc_d is all-ones; <= 0 when all-zeros; otherwise holds.
  - Low counter clears while after_hyst==1 and increments while 0.
  - At 2^HYST_W-1 the counter wraps to 0 and after_hyst is forced to 1.
- Serializer:
  - Shift register {out_i, out_q} of 2*OUT_W bits is loaded at cnt==0; ssp_din = MSB.
  - Shift occurs at every cnt[1:0]==00 except cnt==0, zero-filling.
  - After 2*OUT_W bits, ssp_din stays 0 until the next load.

## Timing
- ssp_clk <= 1 at cnt[1:0]==00 and <= 0 at cnt[1:0]==10; runs continuously.
- ssp_frame high for cnt 0..3 (registered in the same edge as the load).
- Latency: the window of samples at cnt 0..N-1 is reported at the next cnt==0 edge.
  - corr_valid pulses for that single cycle.
  - The first bit is on ssp_din in the same cycle.
  - The last bit is shifted at cnt==4*(2*OUT_W-1).
- Reset value 0 on every register: cnt, accumulators, shift register, after_hyst, low counter, and shadow registers. All outputs are therefore 0 during reset.
- First window after reset is not complete: corr_valid is suppressed and tag_detect held 0 at the first cnt==0 edge. A primed flag sets after that edge.
- Reset mid-window or mid-serialization: immediate async clear, no partial word emitted. After release, the same first-window suppression applies.
- All-ones and all-zeros cannot occur together; timeout wrap and an all-ones sample in the same cycle give after_hyst=1.

## Test plan
- Constant adc_d=128, sc_mode=00, gain_shift=4, snoop=0, WIN_LOG2=7 -> out_i=0, out_q=0, tag_detect=0 every window; corr_valid every 128 cycles; first window after reset has no pulse.
- adc_d=200 when cnt[3]==0 else 100, sc_mode=00, gain_shift=6, thresh=50 -> acc_i=6400, out_i=100 (0x64), out_q=0, tag_detect=1; ssp_din serial sequence 0x64 then 0x00 with ssp_frame high for cnt 0..3.
- Same stimulus with gain_shift=0 -> out_i=127; levels swapped -> out_i=-128 (0x80).
- snoop=1: drive 255 for 10 samples, then 0 for 5000 samples -> after_hyst falls to 0, returns to 1 after 4096 low samples; embedded LSBs track it with the specified window delays.
- Change sc_mode 00->10 at cnt=40 -> current window correlates at 848 kHz; the next window at 212 kHz (b=5).
- Assert reset at cnt=10 of serialization -> ssp_din, ssp_clk, ssp_frame, corr_valid immediately 0; after release, no corr_valid at the first wrap, valid pulse at the second.

Source files
------------

// File: rtl/hi_read_rx_xcorr_mc_if.sv
// Bundles the correlator's run-time controls, sample input and SSP-side outputs.
// The master side drives the sample and controls; the slave side is the correlator.
interface hi_read_rx_xcorr_mc_if #(
  parameter int ADC_W = 8,
  parameter int OUT_W = 8
);
  logic [ADC_W-1:0] adc_d;
  logic [1:0]       sc_mode;
  logic [3:0]       gain_shift;
  logic [OUT_W-1:0] thresh;
  logic             snoop;
  logic             ssp_clk;
  logic             ssp_frame;
  logic             ssp_din;
  logic             corr_valid;
  logic             tag_detect;
  logic             dbg;

  modport master (
    output adc_d, sc_mode, gain_shift, thresh, snoop,
    input  ssp_clk, ssp_frame, ssp_din, corr_valid, tag_detect, dbg
  );

  modport slave (
    input  adc_d, sc_mode, gain_shift, thresh, snoop,
    output ssp_clk, ssp_frame, ssp_din, corr_valid, tag_detect, dbg
  );
endinterface

// File: rtl/hi_read_rx_xcorr_mc.sv
// HF reader-mode subcarrier correlator: correlates ADC samples against I/Q
// square-wave references over a 2^WIN_LOG2 window, then shifts the saturated
// I/Q pair out over SSP, optionally carrying the reader AM hysteresis bit.
module hi_read_rx_xcorr_mc #(
  parameter int ADC_W    = 8,
  parameter int WIN_LOG2 = 7,
  parameter int OUT_W    = 8,
  parameter int HYST_W   = 12
) (
  input logic                   adc_clk,
  input logic                   reset,
  hi_read_rx_xcorr_mc_if.slave  bus
);

  localparam int ACC_W = ADC_W + WIN_LOG2 + 1;
  localparam int SR_W  = 2 * OUT_W;
  localparam int IDX_W = $clog2(WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_HALF = {1'b1, {(WIN_LOG2-1){1'b0}}};

  logic [WIN_LOG2-1:0]     cnt;
  logic [1:0]              sc_mode_q;
  logic [3:0]              gain_shift_q;
  logic [OUT_W-1:0]        thresh_q;
  logic                    snoop_q;
  logic                    primed;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] adc_ext;
  logic                    after_hyst;
  logic [HYST_W-1:0]       low_cnt;
  logic                    hbit_i;
  logic                    hbit_q;
  logic [SR_W-1:0]         shift_reg;
  logic                    ssp_clk_q;
  logic                    ssp_frame_q;
  logic                    corr_valid_q;
  logic                    tag_detect_q;

  int                      ref_b_int;
  logic [IDX_W-1:0]        ref_b;
  logic [IDX_W-1:0]        ref_b_lo;
  logic                    ref_i;
  logic                    ref_q;

  logic signed [ACC_W-1:0] s_i, s_q, c_i, c_q, cs_i, cs_q;
  logic [OUT_W-1:0]        norm_i, norm_q, out_i, out_q;
  logic [OUT_W:0]          abs_i, abs_q, mag_sum;
  logic                    tag_next;

  // Clamp a signed value to the range of a w-bit two's-complement word.
  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v,
                                                    input int w);
    logic signed [ACC_W-1:0] hi_lim;
    logic signed [ACC_W-1:0] lo_lim;
    hi_lim = ACC_W'((1 << (w - 1)) - 1);
    lo_lim = ~hi_lim;
    if (v > hi_lim)      return hi_lim;
    else if (v < lo_lim) return lo_lim;
    else                 return v;
  endfunction

  assign adc_ext = signed'({{(ACC_W-ADC_W){1'b0}}, bus.adc_d});

  // Select the reference bit for the captured subcarrier rate and derive I/Q references.
  always_comb begin
    ref_b_int = 3 + int'(sc_mode_q);
    if (ref_b_int > WIN_LOG2 - 1) ref_b_int = WIN_LOG2 - 1;
    ref_b    = IDX_W'(ref_b_int);
    ref_b_lo = IDX_W'(ref_b_int - 1);
    ref_i    = ~cnt[ref_b];
    ref_q    = ~(cnt[ref_b] ^ cnt[ref_b_lo]);
  end

  // Scale and saturate the finished window into output words and the tag-detect decision.
  always_comb begin
    s_i    = acc_i >>> gain_shift_q;
    s_q    = acc_q >>> gain_shift_q;
    c_i    = clamp(s_i, OUT_W);
    c_q    = clamp(s_q, OUT_W);
    cs_i   = clamp(s_i >>> 1, OUT_W - 1);
    cs_q   = clamp(s_q >>> 1, OUT_W - 1);
    norm_i = c_i[OUT_W-1:0];
    norm_q = c_q[OUT_W-1:0];
    out_i  = snoop_q ? {cs_i[OUT_W-2:0], hbit_i} : norm_i;
    out_q  = snoop_q ? {cs_q[OUT_W-2:0], hbit_q} : norm_q;
    abs_i  = norm_i[OUT_W-1] ? ({1'b0, ~norm_i} + (OUT_W+1)'(1)) : {1'b0, norm_i};
    abs_q  = norm_q[OUT_W-1] ? ({1'b0, ~norm_q} + (OUT_W+1)'(1)) : {1'b0, norm_q};
    mag_sum  = abs_i + abs_q;
    tag_next = (mag_sum >= {1'b0, thresh_q});
  end

  // Free-running sample counter; controls are sampled only at window start.
  always_ff @(negedge adc_clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      sc_mode_q    <= '0;
      gain_shift_q <= '0;
      thresh_q     <= '0;
      snoop_q      <= 1'b0;
      primed       <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '0) begin
        sc_mode_q    <= bus.sc_mode;
        gain_shift_q <= bus.gain_shift;
        thresh_q     <= bus.thresh;
        snoop_q      <= bus.snoop;
        primed       <= 1'b1;
      end
    end
  end

  // Correlate: restart with +sample at window start, otherwise add/subtract per reference.
  always_ff @(negedge adc_clk or posedge reset) begin
    if (reset) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (cnt == '0) begin
      acc_i <= adc_ext;
      acc_q <= adc_ext;
    end else begin
      acc_i <= ref_i ? (acc_i + adc_ext) : (acc_i - adc_ext);
      acc_q <= ref_q ? (acc_q + adc_ext) : (acc_q - adc_ext);
    end
  end

  // Reader AM hysteresis with low-timeout, plus snapshots for the embedded snoop bits.
  always_ff @(negedge adc_clk or posedge reset) begin
    if (reset) begin
      after_hyst <= 1'b0;
      low_cnt    <= '0;
      hbit_i     <= 1'b0;
      hbit_q     <= 1'b0;
    end else begin
      if (after_hyst)            low_cnt <= '0;
      else if (low_cnt == '1)    low_cnt <= '0;
      else                       low_cnt <= low_cnt + 1'b1;
      if (bus.adc_d == '1)       after_hyst <= 1'b1;
      else if (bus.adc_d == '0)  after_hyst <= 1'b0;
      if (!after_hyst && low_cnt == '1) after_hyst <= 1'b1;
      if (cnt == '0)             hbit_i <= after_hyst;
      if (cnt == CNT_HALF)       hbit_q <= after_hyst;
    end
  end

  // Load the finished I/Q pair at window start and shift it out MSB first on SSP.
  always_ff @(negedge adc_clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      ssp_clk_q    <= 1'b0;
      ssp_frame_q  <= 1'b0;
      corr_valid_q <= 1'b0;
      tag_detect_q <= 1'b0;
    end else begin
      corr_valid_q <= (cnt == '0) && primed;
      ssp_frame_q  <= (cnt[WIN_LOG2-1:2] == '0);
      if (cnt[1:0] == 2'b00)      ssp_clk_q <= 1'b1;
      else if (cnt[1:0] == 2'b10) ssp_clk_q <= 1'b0;
      if (cnt == '0) begin
        shift_reg <= {out_i, out_q};
        if (primed) tag_detect_q <= tag_next;
      end else if (cnt[1:0] == 2'b00) begin
        shift_reg <= {shift_reg[SR_W-2:0], 1'b0};
      end
    end
  end

  assign bus.ssp_clk    = ssp_clk_q;
  assign bus.ssp_frame  = ssp_frame_q;
  assign bus.ssp_din    = shift_reg[SR_W-1];
  assign bus.corr_valid = corr_valid_q;
  assign bus.tag_detect = tag_detect_q;
  assign bus.dbg        = cnt[3];

endmodule
